// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction fetch stage placed directly in front of a combinational 32-bit
// instruction ROM. It owns the program counter, drives the ROM byte address,
// captures the returned word into the IF/ID register and hands it to decode
// through a valid/ready handshake. Branch redirects flush the stage and
// restart fetch. Fetch halts after delivering the instruction at PC_LIMIT.
//
// Ports:
//   clk            in   1       system clock, rising edge
//   reset          in   1       asynchronous, active-high reset
//   rom_address    out  ADDR_W  ROM byte address, word aligned, from pc
//   rom_data       in   DATA_W  combinational ROM word at rom_address
//   out_instr      out  DATA_W  registered instruction
//   out_pc         out  32      byte address of out_instr
//   out_pc_plus8   out  32      out_pc + 8 (ARM PC read value)
//   out_valid      out  1       out_* holds a valid instruction
//   out_ready      in   1       decode accepts out_* this cycle
//   redirect_valid in   1       branch taken / flush request
//   redirect_pc    in   32      redirect target byte address
//   halted         out  1       fetch sits in its HALT state
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_00FC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus8,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // pc is kept word aligned at all times, including its reset value.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [31:0]         pc_r;
    logic [DATA_W-1:0]   instr_r;
    logic [31:0]         opc_r;
    logic [31:0]         opc8_r;
    logic                valid_r;
    logic                halted_r;

    logic                free_s;
    logic                capture_s;
    logic [31:0]         pc_plus4_s;
    logic [31:0]         redirect_target_s;
    logic [31:0]         pc_nxt_s;
    logic                valid_nxt_s;
    logic                halted_nxt_s;

    // The IF/ID slot can take a new word when it is empty or being drained.
    assign free_s            = !valid_r || out_ready;
    assign pc_plus4_s        = pc_r + 32'd4;
    // Misaligned targets are truncated to the containing word.
    assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;

    // ROM addressing only sees the low pc bits; upper bits still go to out_pc.
    assign rom_address  = {pc_r[ADDR_W-1:2], 2'b00};
    assign out_instr    = instr_r;
    assign out_pc       = opc_r;
    assign out_pc_plus8 = opc8_r;
    assign out_valid    = valid_r;
    assign halted       = halted_r;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a redirect always lands in RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    state_nxt_s = ST_RUN;
                end else if (free_s && (pc_r == PC_LIMIT)) begin
                    // The last instruction is captured on this edge, then stop.
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: capture strobe plus next values of pc, valid, halted.
    always_comb begin
        capture_s    = 1'b0;
        pc_nxt_s     = pc_r;
        valid_nxt_s  = valid_r;
        halted_nxt_s = halted_r;
        if (redirect_valid) begin
            // Flush: nothing captured this cycle, fetch restarts at the target.
            capture_s    = 1'b0;
            pc_nxt_s     = redirect_target_s;
            valid_nxt_s  = 1'b0;
            halted_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    capture_s    = 1'b0;
                    pc_nxt_s     = pc_r;
                    valid_nxt_s  = valid_r;
                    halted_nxt_s = 1'b0;
                end
                ST_RUN: begin
                    if (free_s) begin
                        capture_s    = 1'b1;
                        pc_nxt_s     = pc_plus4_s;
                        valid_nxt_s  = 1'b1;
                        halted_nxt_s = (pc_r == PC_LIMIT);
                    end else begin
                        // Stall: everything holds.
                        capture_s    = 1'b0;
                        pc_nxt_s     = pc_r;
                        valid_nxt_s  = valid_r;
                        halted_nxt_s = 1'b0;
                    end
                end
                ST_HALT: begin
                    capture_s    = 1'b0;
                    pc_nxt_s     = pc_r;
                    halted_nxt_s = 1'b1;
                    if (out_ready) begin
                        // Pending instruction drained by decode.
                        valid_nxt_s = 1'b0;
                    end else begin
                        valid_nxt_s = valid_r;
                    end
                end
                default: begin
                    capture_s    = 1'b0;
                    pc_nxt_s     = pc_r;
                    valid_nxt_s  = 1'b0;
                    halted_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Program counter, valid and halted flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_PC_ALIGNED;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_nxt_s;
            valid_r  <= valid_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    // IF/ID payload register; only loaded on a capture so a stall holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r <= {DATA_W{1'b0}};
            opc_r   <= 32'd0;
            opc8_r  <= 32'd0;
        end else if (capture_s) begin
            instr_r <= rom_data;
            opc_r   <= pc_r;
            opc8_r  <= pc_r + 32'd8;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Bench for instr_fetch_stage: a directed prologue with literal expectations
// following the fetch, backpressure, redirect, halt and async-reset scenarios,
// then a randomized phase. A behavioural model of the stage (program counter,
// delivered-instruction slot, run/halt mode) is compared against the DUT on
// every falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned DATA_W   = 32;
    localparam logic [31:0] PC_LIMIT = 32'h0000_00FC;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc_plus8;
    logic              out_valid;
    logic              out_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halted;

    logic [31:0] rom [0:511];

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_stage #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(32'h0000_0000),
        .PC_LIMIT(PC_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus8  (out_pc_plus8),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Combinational ROM.
    assign rom_data = rom[rom_address[10:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int          m_mode;
    logic [31:0] m_pc;      // next fetch address
    logic        m_has;     // an undelivered instruction is presented
    logic [31:0] m_instr;
    logic [31:0] m_at;      // address of the presented instruction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= M_IDLE;
            m_pc    <= 32'd0;
            m_has   <= 1'b0;
            m_instr <= 32'd0;
            m_at    <= 32'd0;
        end else if (redirect_valid) begin
            m_mode <= M_RUN;
            m_pc   <= (redirect_pc / 32'd4) * 32'd4;
            m_has  <= 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_mode <= M_RUN;
        end else if (m_mode == M_RUN && (out_ready || !m_has)) begin
            m_instr <= rom[(m_pc % 32'd2048) / 32'd4];
            m_at    <= m_pc;
            m_has   <= 1'b1;
            m_pc    <= m_pc + 32'd4;
            if (m_pc == PC_LIMIT) m_mode <= M_HALT;
        end else if (m_mode == M_HALT && out_ready) begin
            m_has <= 1'b0;
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        check("rom_address", {21'd0, rom_address}, (m_pc % 32'd2048));
        check("out_valid", {31'd0, out_valid}, {31'd0, m_has});
        check("halted", {31'd0, halted}, (m_mode == M_HALT) ? 32'd1 : 32'd0);
        if (m_has) begin
            check("out_instr", out_instr, m_instr);
            check("out_pc", out_pc, m_at);
            check("out_pc_plus8", out_pc_plus8, m_at + 32'd8);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scenario 1 after reset release (reset released between edges).
    task automatic startup_checks(input string tag);
        tick();   // IDLE bubble
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_addr"}, {21'd0, rom_address}, 32'h000);
        tick();
        check({tag, "_w0_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_w0_instr"}, out_instr, 32'h0000_0001);
        check({tag, "_w0_pc"}, out_pc, 32'd0);
        check({tag, "_w0_pc8"}, out_pc_plus8, 32'd8);
        check({tag, "_w0_addr"}, {21'd0, rom_address}, 32'h004);
        tick();
        check({tag, "_w1_instr"}, out_instr, 32'h0000_0200);
        check({tag, "_w1_pc"}, out_pc, 32'd4);
        check({tag, "_w1_addr"}, {21'd0, rom_address}, 32'h008);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        rom[0]  = 32'h0000_0001;
        rom[1]  = 32'h0000_0200;
        rom[2]  = 32'hDEAD_0008;
        rom[3]  = 32'hDEAD_000C;
        rom[49] = 32'hC4C4_C4C4;
        rom[63] = 32'hFCFC_FCFC;

        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_pc8", out_pc_plus8, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_addr", {21'd0, rom_address}, 32'd0);
        #11 reset = 1'b0;    // t=12, between edges

        startup_checks("s1");

        // Scenario 2: backpressure at out_pc=0x008.
        tick();
        check("s2_pc", out_pc, 32'h008);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_stall_pc", out_pc, 32'h008);
            check("s2_stall_instr", out_instr, 32'hDEAD_0008);
            check("s2_stall_addr", {21'd0, rom_address}, 32'h00C);
            check("s2_stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("s2_resume_pc", out_pc, 32'h00C);
        check("s2_resume_instr", out_instr, 32'hDEAD_000C);

        // Scenario 3: misaligned redirect during a stall.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_00C7;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        check("s3_addr", {21'd0, rom_address}, 32'h0C4);
        tick();
        check("s3_valid", {31'd0, out_valid}, 32'd1);
        check("s3_pc", out_pc, 32'h0C4);
        check("s3_instr", out_instr, 32'hC4C4_C4C4);

        // Scenario 4: run through 0x0C8..0x0FC and halt.
        for (int i = 0; i < 14; i++) tick();
        check("s4_last_pc", out_pc, 32'h0FC);
        check("s4_last_instr", out_instr, 32'hFCFC_FCFC);
        check("s4_last_valid", {31'd0, out_valid}, 32'd1);
        check("s4_halted", {31'd0, halted}, 32'd1);
        check("s4_addr", {21'd0, rom_address}, 32'h100);
        tick();
        check("s4_drained", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("s4_still_halted", {31'd0, halted}, 32'd1);
        check("s4_still_empty", {31'd0, out_valid}, 32'd0);
        check("s4_pc_hold", {21'd0, rom_address}, 32'h100);

        // Scenario 5: redirect out of HALT.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0000;
        tick();
        redirect_valid = 1'b0;
        check("s5_unhalt", {31'd0, halted}, 32'd0);
        check("s5_addr", {21'd0, rom_address}, 32'h000);
        tick();
        check("s5_valid", {31'd0, out_valid}, 32'd1);
        check("s5_instr", out_instr, 32'h0000_0001);
        check("s5_pc", out_pc, 32'd0);
        tick();
        tick();

        // Scenario 6: asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("s6_valid", {31'd0, out_valid}, 32'd0);
        check("s6_instr", out_instr, 32'd0);
        check("s6_addr", {21'd0, rom_address}, 32'h000);
        #1 reset = 1'b0;
        startup_checks("s6");

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = $urandom_range(0, 32'h103);
                default: redirect_pc = 32'h0C0 + $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
